// File: rtl/copy_job_arbiter_if.sv
// Bus between the copy-job arbiter and its environment (requesters + copy engine).
// Signals:
//   req_i/src_addr_i/dst_addr_i/len_i  per-requester job requests, flattened by index
//   grant_o/done_o/err_o/busy_o        per-requester grant and completion status
//   eng_*                              start/abort/job fields to the engine, idle/done back
// Modports: slave = arbiter side, master = requesters/engine side.
interface copy_job_arbiter_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16
);
  logic [NREQ-1:0]        req_i;
  logic [NREQ*ADDR_W-1:0] src_addr_i;
  logic [NREQ*ADDR_W-1:0] dst_addr_i;
  logic [NREQ*LEN_W-1:0]  len_i;
  logic [NREQ-1:0]        grant_o;
  logic [NREQ-1:0]        done_o;
  logic                   err_o;
  logic                   busy_o;
  logic                   eng_start_o;
  logic                   eng_abort_o;
  logic [ADDR_W-1:0]      eng_src_o;
  logic [ADDR_W-1:0]      eng_dst_o;
  logic [LEN_W-1:0]       eng_len_o;
  logic                   eng_idle_i;
  logic                   eng_done_i;

  modport slave (
    input  req_i, src_addr_i, dst_addr_i, len_i, eng_idle_i, eng_done_i,
    output grant_o, done_o, err_o, busy_o, eng_start_o, eng_abort_o,
           eng_src_o, eng_dst_o, eng_len_o
  );

  modport master (
    output req_i, src_addr_i, dst_addr_i, len_i, eng_idle_i, eng_done_i,
    input  grant_o, done_o, err_o, busy_o, eng_start_o, eng_abort_o,
           eng_src_o, eng_dst_o, eng_len_o
  );
endinterface

// File: rtl/copy_job_arbiter.sv
// Round-robin scheduler of block-copy jobs from NREQ requesters onto one copy engine.
// Latches the winner's src/dst/len, pulses engine start once the engine is idle,
// waits for done under a watchdog (abort + error on timeout) and returns a
// one-cycle done pulse to the granted requester.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         copy_job_arbiter_if.slave (requests, grants, engine control/status)
// eng_start_o and eng_abort_o are combinational (gated by eng_idle_i / eng_done_i);
// all other outputs are registered.
module copy_job_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input logic                clk,
  input logic                rst_n,
  copy_job_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [NREQ-1:0]   grant_q, done_q;
  logic              err_q, err_d;
  logic              busy_q;
  logic              timeout_hit;

  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W:0]    cand;

  // Round-robin search: first set request at or above the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NREQ)) cand = cand - (IDX_W+1)'(NREQ);
      if (!win_found && bus.req_i[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign timeout_hit = (wdog_q == WD_W'(TIMEOUT - 1));

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    wdog_d  = wdog_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          idx_d   = win_idx;
          src_d   = bus.src_addr_i[32'(win_idx)*ADDR_W +: ADDR_W];
          dst_d   = bus.dst_addr_i[32'(win_idx)*ADDR_W +: ADDR_W];
          len_d   = bus.len_i[32'(win_idx)*LEN_W +: LEN_W];
          // Zero-length jobs complete without touching the engine.
          state_d = (len_d == '0) ? S_DONE : S_START;
        end
      end
      S_START: begin
        if (bus.eng_idle_i) begin
          state_d = S_WAIT;
          wdog_d  = '0;
        end
      end
      S_WAIT: begin
        wdog_d = wdog_q + WD_W'(1);
        // Engine done wins over a same-cycle timeout.
        if (bus.eng_done_i) begin
          state_d = S_DONE;
        end else if (timeout_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_DONE: begin
        ptr_d   = (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + IDX_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs (decoded from next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      wdog_q  <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      wdog_q  <= wdog_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      grant_q <= (state_d != S_IDLE) ? (NREQ'(1) << idx_d) : '0;
      done_q  <= (state_d == S_DONE) ? (NREQ'(1) << idx_d) : '0;
      err_q   <= err_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign bus.grant_o     = grant_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.busy_o      = busy_q;
  assign bus.eng_src_o   = src_q;
  assign bus.eng_dst_o   = dst_q;
  assign bus.eng_len_o   = len_q;
  assign bus.eng_start_o = (state_q == S_START) && bus.eng_idle_i;
  assign bus.eng_abort_o = (state_q == S_WAIT) && !bus.eng_done_i && timeout_hit;

endmodule

// File: tb/tb_copy_job_arbiter.sv
// Directed self-checking bench for copy_job_arbiter (NREQ=4, TIMEOUT=16).
module tb_copy_job_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned TIMEOUT = 16;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  copy_job_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  copy_job_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] src_of(input int k);
    return 32'h1000_0000 + 32'(k) * 32'h100;
  endfunction

  function automatic logic [31:0] dst_of(input int k);
    return 32'h2000_0000 + 32'(k) * 32'h100;
  endfunction

  task automatic set_len(input int k, input logic [15:0] l);
    bus.len_i[k*LEN_W +: LEN_W] = l;
  endtask

  // One full job from IDLE: start, wait_cyc extra WAIT cycles, engine done, back to IDLE.
  task automatic run_job(input int k, input logic [15:0] l, input int wait_cyc, input bit drop_req);
    step();  // START
    chk("grant_start", 64'(bus.grant_o), 64'(1) << k);
    chk("eng_start", 64'(bus.eng_start_o), 64'd1);
    chk("eng_src", 64'(bus.eng_src_o), 64'(src_of(k)));
    chk("eng_dst", 64'(bus.eng_dst_o), 64'(dst_of(k)));
    chk("eng_len", 64'(bus.eng_len_o), 64'(l));
    chk("busy", 64'(bus.busy_o), 64'd1);
    step();  // WAIT
    chk("start_one_pulse", 64'(bus.eng_start_o), 64'd0);
    chk("grant_wait", 64'(bus.grant_o), 64'(1) << k);
    if (drop_req) bus.req_i = '0;
    repeat (wait_cyc) step();
    chk("no_early_done", 64'(bus.done_o), 64'd0);
    bus.eng_done_i = 1'b1;
    step();  // DONE
    bus.eng_done_i = 1'b0;
    chk("done", 64'(bus.done_o), 64'(1) << k);
    chk("err_clean", 64'(bus.err_o), 64'd0);
    chk("grant_done", 64'(bus.grant_o), 64'(1) << k);
    step();  // IDLE
    chk("grant_idle", 64'(bus.grant_o), 64'd0);
    chk("done_cleared", 64'(bus.done_o), 64'd0);
    chk("busy_idle", 64'(bus.busy_o), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.req_i      = '0;
    bus.eng_idle_i = 1'b1;
    bus.eng_done_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.src_addr_i[k*ADDR_W +: ADDR_W] = src_of(k);
      bus.dst_addr_i[k*ADDR_W +: ADDR_W] = dst_of(k);
      bus.len_i[k*LEN_W +: LEN_W]        = 16'd4;
    end

    // 1: reset values, then a single job of length 8 (req dropped mid-job).
    step();
    chk("rst_grant", 64'(bus.grant_o), 64'd0);
    chk("rst_done", 64'(bus.done_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_start", 64'(bus.eng_start_o), 64'd0);
    chk("rst_len", 64'(bus.eng_len_o), 64'd0);
    rst_n = 1'b1;
    step();
    set_len(0, 16'd8);
    bus.req_i = 4'b0001;
    run_job(0, 16'd8, 7, 1'b1);
    chk("fields_hold", 64'(bus.eng_src_o), 64'(src_of(0)));

    // 2: all four requesting from a fresh pointer: order 0,1,2,3,0.
    do_reset();
    for (int k = 0; k < 4; k++) set_len(k, 16'd4);
    bus.req_i = 4'b1111;
    run_job(0, 16'd4, 2, 1'b0);
    run_job(1, 16'd4, 2, 1'b0);
    run_job(2, 16'd4, 2, 1'b0);
    run_job(3, 16'd4, 2, 1'b0);
    bus.req_i = 4'b1111;
    run_job(0, 16'd4, 2, 1'b0);
    bus.req_i = '0;
    step();

    // 3: zero-length job on requester 2 goes straight to DONE (pointer is 1).
    set_len(2, 16'd0);
    bus.req_i = 4'b0100;
    step();
    chk("zl_done", 64'(bus.done_o), 64'b0100);
    chk("zl_grant", 64'(bus.grant_o), 64'b0100);
    chk("zl_no_start", 64'(bus.eng_start_o), 64'd0);
    chk("zl_err", 64'(bus.err_o), 64'd0);
    chk("zl_len", 64'(bus.eng_len_o), 64'd0);
    bus.req_i = '0;
    step();
    chk("zl_idle", 64'(bus.done_o), 64'd0);
    chk("zl_no_start2", 64'(bus.eng_start_o), 64'd0);

    // 4: engine busy for 5 cycles after grant; start waits for idle (pointer 3).
    bus.eng_idle_i = 1'b0;
    bus.req_i = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("hold_grant", 64'(bus.grant_o), 64'b1000);
      chk("hold_no_start", 64'(bus.eng_start_o), 64'd0);
    end
    bus.eng_idle_i = 1'b1;
    #1;
    chk("late_start", 64'(bus.eng_start_o), 64'd1);
    step();
    chk("late_start_once", 64'(bus.eng_start_o), 64'd0);
    bus.eng_done_i = 1'b1;
    step();
    bus.eng_done_i = 1'b0;
    bus.req_i = '0;
    chk("late_done", 64'(bus.done_o), 64'b1000);
    step();

    // 5: watchdog timeout on requester 0 (pointer 0); engine never finishes.
    set_len(0, 16'd8);
    bus.req_i = 4'b0001;
    step();  // START
    step();  // WAIT cycle 1
    chk("to_no_abort_1", 64'(bus.eng_abort_o), 64'd0);
    repeat (14) step();  // WAIT cycle 15
    chk("to_no_abort_15", 64'(bus.eng_abort_o), 64'd0);
    step();  // WAIT cycle 16
    chk("to_abort", 64'(bus.eng_abort_o), 64'd1);
    chk("to_no_done_yet", 64'(bus.done_o), 64'd0);
    step();  // DONE
    chk("to_done", 64'(bus.done_o), 64'b0001);
    chk("to_err", 64'(bus.err_o), 64'd1);
    chk("to_abort_once", 64'(bus.eng_abort_o), 64'd0);
    bus.req_i = '0;
    step();
    chk("to_err_clear", 64'(bus.err_o), 64'd0);
    // Pointer advanced to 1: with 0 and 1 requesting, 1 wins.
    bus.req_i = 4'b0011;
    step();
    chk("to_ptr_adv", 64'(bus.grant_o), 64'b0010);

    // 6: reset mid-WAIT, then a pending request on requester 1 is a fresh job.
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("arst_grant", 64'(bus.grant_o), 64'd0);
    chk("arst_busy", 64'(bus.busy_o), 64'd0);
    chk("arst_done", 64'(bus.done_o), 64'd0);
    chk("arst_abort", 64'(bus.eng_abort_o), 64'd0);
    chk("arst_src", 64'(bus.eng_src_o), 64'd0);
    bus.req_i = 4'b0010;
    step();
    chk("arst_no_done", 64'(bus.done_o), 64'd0);
    rst_n = 1'b1;
    run_job(1, 16'd4, 1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
